// File: rtl/game_pkg.sv
// game_pkg: shared constants, state encoding and helpers for the game sequencer
package game_pkg;

    localparam int NUM_PLAYERS = 4;
    localparam int CNT_W       = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RUN       = 2'd2,
        OVER      = 2'd3
    } state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// tick_timer: loadable frame-tick down counter with a zero flag
module tick_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    // reload on state entry, otherwise count down one per frame tick and stop at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && tick && !zero)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: round controller from lobby through countdown, play and game-over
module game_sequencer
    import game_pkg::*;
#(
    parameter int COUNTDOWN_TICKS = 180,
    parameter int GAMEOVER_TICKS  = 300,
    parameter int SCORE_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   start,
    input  logic [NUM_PLAYERS-1:0] p_en,
    input  logic [NUM_PLAYERS-1:0] dead,
    output logic [NUM_PLAYERS-1:0] play,
    output logic                   enable_board,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       count,
    output logic [NUM_PLAYERS-1:0] alive,
    output logic [1:0]             winner,
    output logic                   winner_valid,
    output logic [SCORE_W-1:0]     score
);

    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COUNTDOWN_TICKS - 1);
    localparam logic [CNT_W-1:0] GO_LOAD = CNT_W'(GAMEOVER_TICKS - 1);

    state_t                   st;
    logic                     start_q;
    logic                     start_rise;
    logic [NUM_PLAYERS-1:0]   live;
    logic [2:0]               n_live;
    logic                     game_end;
    logic [1:0]               win_idx;
    logic                     t_load;
    logic                     t_zero;

    assign state      = st;
    assign start_rise = start & ~start_q;
    assign live       = play & ~dead;
    assign n_live     = popcount4(live);
    // multi-player rounds end at one survivor, solo rounds only when the player dies
    assign game_end   = (st == RUN) && ((popcount4(play) >= 3'd2) ? (n_live <= 3'd1) : (n_live == 3'd0));
    assign t_load     = ((st == IDLE) && start_rise && |p_en) || game_end;

    // index of the lowest surviving player; only meaningful with exactly one survivor
    always_comb begin
        win_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--)
            if (live[i]) win_idx = 2'(i);
    end

    tick_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (game_end ? GO_LOAD : CD_LOAD),
        .en       ((st == COUNTDOWN) || (st == OVER)),
        .tick     (tick),
        .count    (count),
        .zero     (t_zero)
    );

    // round state machine with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= IDLE;
            start_q      <= 1'b0;
            play         <= '0;
            alive        <= '0;
            enable_board <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            score        <= '0;
        end else begin
            start_q <= start;
            alive   <= live;
            case (st)
                IDLE: begin
                    if (start_rise && |p_en) begin
                        st           <= COUNTDOWN;
                        play         <= p_en;
                        score        <= '0;
                        winner       <= '0;
                        winner_valid <= 1'b0;
                    end
                end
                COUNTDOWN: begin
                    if (tick && t_zero) begin
                        st           <= RUN;
                        enable_board <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick && (score != {SCORE_W{1'b1}}))
                        score <= score + 1'b1;
                    if (game_end) begin
                        st           <= OVER;
                        enable_board <= 1'b0;
                        winner_valid <= (n_live == 3'd1);
                        winner       <= (n_live == 3'd1) ? win_idx : 2'd0;
                    end
                end
                OVER: begin
                    if (tick && t_zero) begin
                        st   <= IDLE;
                        play <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard-driven self-checking bench for game_sequencer
module tb_game_sequencer;

    typedef struct packed {
        logic [1:0]  st;
        logic [3:0]  play;
        logic        en;
        logic [3:0]  alive;
        logic [1:0]  win;
        logic        wv;
        logic [15:0] score;
        logic [8:0]  count;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0, start = 1'b0;
    logic [3:0]  p_en = '0, dead = '0;
    logic [3:0]  play, alive;
    logic        enable_board, winner_valid;
    logic [1:0]  state, winner;
    logic [8:0]  count;
    logic [15:0] score;

    logic        s_tick = 1'b0, s_start = 1'b0;
    logic [3:0]  s_pen = '0, s_dead = '0;
    logic [3:0]  s_play, s_alive;
    logic        s_en, s_wv;
    logic [1:0]  s_state, s_winner;
    logic [8:0]  s_count;
    logic [3:0]  s_score;

    snap_t       exp_q[$];
    logic [5:0]  sat_q[$];
    snap_t       e, o;
    logic [5:0]  se, so;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .p_en(p_en), .dead(dead),
        .play(play), .enable_board(enable_board), .state(state), .count(count),
        .alive(alive), .winner(winner), .winner_valid(winner_valid), .score(score)
    );

    game_sequencer #(.COUNTDOWN_TICKS(1), .GAMEOVER_TICKS(1), .SCORE_W(4)) dut_sat (
        .clk(clk), .reset(reset), .tick(s_tick), .start(s_start), .p_en(s_pen), .dead(s_dead),
        .play(s_play), .enable_board(s_en), .state(s_state), .count(s_count),
        .alive(s_alive), .winner(s_winner), .winner_valid(s_wv), .score(s_score)
    );

    function automatic snap_t snap();
        snap_t s;
        s.st = state; s.play = play; s.en = enable_board; s.alive = alive;
        s.win = winner; s.wv = winner_valid; s.score = score; s.count = count;
        return s;
    endfunction

    function automatic snap_t mk(logic [1:0] st, logic [3:0] pl, logic en, logic [3:0] al,
                                 logic [1:0] w, logic wv, logic [15:0] sc, logic [8:0] c);
        snap_t s;
        s.st = st; s.play = pl; s.en = en; s.alive = al; s.win = w; s.wv = wv; s.score = sc; s.count = c;
        return s;
    endfunction

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    task automatic test_reset();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL reset_held: got %p exp %p", o, e); n_err++; end
        reset = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL reset_release: got %p exp %p", o, e); n_err++; end
    endtask

    task automatic test_saturation();
        s_pen = 4'b0001; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_tick = 1'b1;
        @(posedge clk); #1;
        s_tick = 1'b0;
        sat_q.push_back({2'd2, 4'd14});
        for (int i = 0; i < 14; i++) begin
            s_tick = 1'b1; @(posedge clk); #1; s_tick = 1'b0; @(posedge clk); #1;
        end
        se = sat_q.pop_front(); so = {s_state, s_score}; n_cmp++;
        if (so !== se) begin $display("FAIL sat_14: got %h exp %h", so, se); n_err++; end
        sat_q.push_back({2'd2, 4'd15});
        for (int i = 0; i < 6; i++) begin
            s_tick = 1'b1; @(posedge clk); #1; s_tick = 1'b0; @(posedge clk); #1;
        end
        se = sat_q.pop_front(); so = {s_state, s_score}; n_cmp++;
        if (so !== se) begin $display("FAIL sat_20: got %h exp %h", so, se); n_err++; end
    endtask

    task automatic test_two_player();
        p_en = 4'b0101; start = 1'b1;
        exp_q.push_back(mk(1, 4'b0101, 0, 0, 0, 0, 0, 179));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL two_start: got %p exp %p", o, e); n_err++; end
        start = 1'b0;
        exp_q.push_back(mk(1, 4'b0101, 0, 4'b0101, 0, 0, 0, 0));
        ticks(179);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL two_cd_end: got %p exp %p", o, e); n_err++; end
        exp_q.push_back(mk(2, 4'b0101, 1, 4'b0101, 0, 0, 0, 0));
        step(1'b1);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL two_run: got %p exp %p", o, e); n_err++; end
        p_en = 4'b1010;
        ticks(5);
        dead = 4'b0001;
        exp_q.push_back(mk(3, 4'b0101, 0, 4'b0100, 2, 1, 5, 299));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL two_over: got %p exp %p", o, e); n_err++; end
        ticks(299);
        exp_q.push_back(mk(0, 0, 0, 4'b0100, 2, 1, 5, 0));
        step(1'b1);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL two_idle: got %p exp %p", o, e); n_err++; end
        dead = '0; p_en = '0;
        step(1'b0);
    endtask

    task automatic test_draw_hold_start();
        p_en = 4'b1111; start = 1'b1;
        exp_q.push_back(mk(1, 4'b1111, 0, 0, 0, 0, 0, 179));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL draw_start: got %p exp %p", o, e); n_err++; end
        p_en = 4'b0011;
        ticks(179);
        exp_q.push_back(mk(2, 4'b1111, 1, 4'b1111, 0, 0, 0, 0));
        step(1'b1);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL draw_run_locked: got %p exp %p", o, e); n_err++; end
        ticks(3);
        dead = 4'b1111;
        exp_q.push_back(mk(3, 4'b1111, 0, 0, 0, 0, 3, 299));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL draw_over: got %p exp %p", o, e); n_err++; end
        ticks(299);
        step(1'b1);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL held_start_no_edge: got %p exp %p", o, e); n_err++; end
        start = 1'b0; dead = '0;
        step(1'b0);
    endtask

    task automatic test_empty_solo();
        p_en = 4'b0000; start = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL empty_start: got %p exp %p", o, e); n_err++; end
        start = 1'b0;
        step(1'b0);
        p_en = 4'b0010; start = 1'b1;
        exp_q.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 0, 179));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL solo_start: got %p exp %p", o, e); n_err++; end
        start = 1'b0;
        ticks(179);
        step(1'b1);
        ticks(7);
        dead = 4'b0001;
        exp_q.push_back(mk(2, 4'b0010, 1, 4'b0010, 0, 0, 7, 0));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL solo_foreign_dead: got %p exp %p", o, e); n_err++; end
        dead = 4'b0011;
        exp_q.push_back(mk(3, 4'b0010, 0, 0, 0, 0, 7, 299));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL solo_over: got %p exp %p", o, e); n_err++; end
        ticks(299);
        step(1'b1);
        dead = '0;
        step(1'b0);
    endtask

    task automatic test_ignore_dead_and_reset_mid_run();
        p_en = 4'b0011; start = 1'b1;
        step(1'b0);
        start = 1'b0;
        ticks(179);
        step(1'b1);
        dead = 4'b1000;
        ticks(2);
        exp_q.push_back(mk(2, 4'b0011, 1, 4'b0011, 0, 0, 2, 0));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL dead3_ignored: got %p exp %p", o, e); n_err++; end
        #2;
        reset = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL async_reset: got %p exp %p", o, e); n_err++; end
        #2;
        reset = 1'b1;
        dead = '0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL after_reset_idle: got %p exp %p", o, e); n_err++; end
        p_en = 4'b0100; start = 1'b1;
        exp_q.push_back(mk(1, 4'b0100, 0, 0, 0, 0, 0, 179));
        step(1'b0);
        e = exp_q.pop_front(); o = snap(); n_cmp++;
        if (o !== e) begin $display("FAIL restart_after_reset: got %p exp %p", o, e); n_err++; end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_two_player();
        test_draw_hold_start();
        test_empty_solo();
        test_ignore_dead_and_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
